// File: rtl/rgmii_link_ctrl.sv
// rtl/rgmii_link_ctrl.sv - RGMII link/speed qualification and adapter bring-up sequencer
module rgmii_link_ctrl #(
    parameter int STABLE_CYCLES = 1024,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter bit PHASE_1G      = 1'b1
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic [3:0] Status,
    input  logic       DcmLocked,
    input  logic       ForceEn,
    input  logic [1:0] ForceSpeed,
    input  logic       ForceDuplex,
    output logic [2:0] Speed,
    output logic       Duplex,
    output logic       RxClkPhase,
    output logic       AdapterRst,
    output logic       CE,
    output logic       LinkUp,
    output logic       LockFail,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        ST_DOWN      = 3'd0,
        ST_QUALIFY   = 3'd1,
        ST_RST_ADAPT = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_UP        = 3'd4
    } state_e;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);

    // Config word layout: [4] forced, [3] link, [2:1] speed, [0] duplex.
    // The forced bit makes a ForceEn toggle look like a config change even
    // when the forced and in-band values happen to agree.
    logic [3:0] status_s1_q, status_s1_d, status_s2_q, status_s2_d;
    logic       lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
    state_e     state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0] cand_q, cand_d;
    logic [2:0] speed_q, speed_d;
    logic       duplex_q, duplex_d;
    logic       phase_q, phase_d;
    logic       adapter_rst_q, adapter_rst_d;
    logic       ce_q, ce_d;
    logic       link_up_q, link_up_d;
    logic       lock_fail_q, lock_fail_d;

    logic [4:0] eff;
    logic       eff_valid;
    logic [2:0] cand_speed_oh;

    // Two-stage synchronizer inputs for Rx-domain status and DCM lock
    always_comb begin
        status_s1_d = Status;
        status_s2_d = status_s1_q;
        lock_s1_d   = DcmLocked;
        lock_s2_d   = lock_s1_q;
    end

    // Effective configuration, either forced or from synchronized status
    always_comb begin
        if (ForceEn) begin
            eff = {1'b1, 1'b1, ForceSpeed, ForceDuplex};
        end else begin
            eff = {1'b0, status_s2_q[0], status_s2_q[2:1], status_s2_q[3]};
        end
        eff_valid = eff[3] && (eff[2:1] != 2'b11);
        case (cand_q[2:1])
            2'b00:   cand_speed_oh = 3'b001;
            2'b01:   cand_speed_oh = 3'b010;
            2'b10:   cand_speed_oh = 3'b100;
            default: cand_speed_oh = 3'b000;
        endcase
    end

    // Next-state, shared counter, latched config and registered output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        cand_d      = cand_q;
        speed_d     = speed_q;
        duplex_d    = duplex_q;
        phase_d     = phase_q;
        lock_fail_d = lock_fail_q;
        case (state_q)
            ST_DOWN: begin
                cnt_d = '0;
                if (eff_valid) begin
                    cand_d  = eff;
                    state_d = ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                if (!eff_valid) begin
                    state_d = ST_DOWN;
                end else if (eff != cand_q) begin
                    cand_d = eff;
                    cnt_d  = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    speed_d  = cand_speed_oh;
                    duplex_d = cand_q[0];
                    phase_d  = (cand_q[2:1] == 2'b10) ? PHASE_1G : 1'b0;
                    state_d  = ST_RST_ADAPT;
                end
            end
            ST_RST_ADAPT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s2_q) begin
                    state_d = ST_UP;
                end else if (cnt_q == LOCK_LAST) begin
                    lock_fail_d = 1'b1;
                    state_d     = ST_RST_ADAPT;
                end
            end
            ST_UP: begin
                cnt_d = '0;
                // A config change outranks a lock drop.
                if (!eff_valid || (eff != cand_q)) begin
                    state_d = ST_DOWN;
                end else if (!lock_s2_q) begin
                    state_d = ST_RST_ADAPT;
                end
            end
            default: begin
                state_d = ST_DOWN;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        if (state_d == ST_DOWN) begin
            speed_d = 3'b000;
        end
        adapter_rst_d = !((state_d == ST_WAIT_LOCK) || (state_d == ST_UP));
        ce_d          = (state_d == ST_UP);
        link_up_d     = (state_d == ST_UP);
    end

    // State, counter, synchronizer and output registers
    always_ff @(posedge Clk) begin
        if (rst) begin
            status_s1_q   <= '0;
            status_s2_q   <= '0;
            lock_s1_q     <= 1'b0;
            lock_s2_q     <= 1'b0;
            state_q       <= ST_DOWN;
            cnt_q         <= '0;
            cand_q        <= '0;
            speed_q       <= 3'b000;
            duplex_q      <= 1'b0;
            phase_q       <= 1'b0;
            adapter_rst_q <= 1'b1;
            ce_q          <= 1'b0;
            link_up_q     <= 1'b0;
            lock_fail_q   <= 1'b0;
        end else begin
            status_s1_q   <= status_s1_d;
            status_s2_q   <= status_s2_d;
            lock_s1_q     <= lock_s1_d;
            lock_s2_q     <= lock_s2_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            speed_q       <= speed_d;
            duplex_q      <= duplex_d;
            phase_q       <= phase_d;
            adapter_rst_q <= adapter_rst_d;
            ce_q          <= ce_d;
            link_up_q     <= link_up_d;
            lock_fail_q   <= lock_fail_d;
        end
    end

    assign Speed      = speed_q;
    assign Duplex     = duplex_q;
    assign RxClkPhase = phase_q;
    assign AdapterRst = adapter_rst_q;
    assign CE         = ce_q;
    assign LinkUp     = link_up_q;
    assign LockFail   = lock_fail_q;
    assign State      = state_q;

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// tb/tb_rgmii_link_ctrl.sv - randomized and directed bench for rgmii_link_ctrl
module tb_rgmii_link_ctrl;

    localparam int SC = 8;
    localparam int RC = 4;
    localparam int LT = 20;

    localparam int M_DOWN = 0;
    localparam int M_QUAL = 1;
    localparam int M_RST  = 2;
    localparam int M_WAIT = 3;
    localparam int M_UP   = 4;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       rst;
    logic [3:0] Status;
    logic       DcmLocked;
    logic       ForceEn;
    logic [1:0] ForceSpeed;
    logic       ForceDuplex;
    logic [2:0] Speed;
    logic       Duplex;
    logic       RxClkPhase;
    logic       AdapterRst;
    logic       CE;
    logic       LinkUp;
    logic       LockFail;
    logic [2:0] State;

    int checks   = 0;
    int failures = 0;

    rgmii_link_ctrl #(
        .STABLE_CYCLES(SC),
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (LT),
        .PHASE_1G     (1'b1)
    ) dut (
        .Clk        (Clk),
        .rst        (rst),
        .Status     (Status),
        .DcmLocked  (DcmLocked),
        .ForceEn    (ForceEn),
        .ForceSpeed (ForceSpeed),
        .ForceDuplex(ForceDuplex),
        .Speed      (Speed),
        .Duplex     (Duplex),
        .RxClkPhase (RxClkPhase),
        .AdapterRst (AdapterRst),
        .CE         (CE),
        .LinkUp     (LinkUp),
        .LockFail   (LockFail),
        .State      (State)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timestamps instead of a counter, history arrays for sync delay
    bit         m_live = 1'b0;
    int         m_state;
    int         m_start;
    int         m_now = 0;
    logic [4:0] m_cand;
    logic [4:0] m_e;
    logic       m_e_ok;
    logic [3:0] st_hist [2];
    logic       lk_hist [2];
    logic [3:0] m_st;
    logic       m_lk;
    logic [2:0] m_speed;
    logic       m_dup;
    logic       m_phase;
    logic       m_lockfail;

    task automatic m_enter(input int s);
        m_state = s;
        m_start = m_now;
        if (s == M_DOWN) m_speed = 3'b000;
    endtask

    always @(posedge Clk) begin
        m_now = m_now + 1;
        if (rst) begin
            m_live     = 1'b1;
            m_state    = M_DOWN;
            m_start    = m_now;
            m_cand     = '0;
            m_speed    = 3'b000;
            m_dup      = 1'b0;
            m_phase    = 1'b0;
            m_lockfail = 1'b0;
            st_hist[0] = '0;
            st_hist[1] = '0;
            lk_hist[0] = 1'b0;
            lk_hist[1] = 1'b0;
        end else if (m_live) begin
            m_st       = st_hist[1];
            m_lk       = lk_hist[1];
            st_hist[1] = st_hist[0];
            st_hist[0] = Status;
            lk_hist[1] = lk_hist[0];
            lk_hist[0] = DcmLocked;
            if (ForceEn) m_e = {2'b11, ForceSpeed, ForceDuplex};
            else         m_e = {1'b0, m_st[0], m_st[2:1], m_st[3]};
            m_e_ok = m_e[3] && (m_e[2:1] != 2'b11);
            case (m_state)
                M_DOWN: if (m_e_ok) begin
                    m_cand = m_e;
                    m_enter(M_QUAL);
                end
                M_QUAL: begin
                    if (!m_e_ok) m_enter(M_DOWN);
                    else if (m_e != m_cand) begin
                        m_cand  = m_e;
                        m_start = m_now;
                    end else if (m_now - m_start == SC) begin
                        m_speed = 3'b001 << m_cand[2:1];
                        m_dup   = m_cand[0];
                        m_phase = (m_cand[2:1] == 2'b10);
                        m_enter(M_RST);
                    end
                end
                M_RST: if (m_now - m_start == RC) m_enter(M_WAIT);
                M_WAIT: begin
                    if (m_lk) m_enter(M_UP);
                    else if (m_now - m_start == LT) begin
                        m_lockfail = 1'b1;
                        m_enter(M_RST);
                    end
                end
                default: begin
                    if (m_e != m_cand) m_enter(M_DOWN);
                    else if (!m_lk) m_enter(M_RST);
                end
            endcase
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge Clk) begin
        if (m_live) begin
            chk("cmp_state",    32'(State),      m_state);
            chk("cmp_speed",    32'(Speed),      32'(m_speed));
            chk("cmp_duplex",   32'(Duplex),     32'(m_dup));
            chk("cmp_phase",    32'(RxClkPhase), 32'(m_phase));
            chk("cmp_arst",     32'(AdapterRst), 32'(m_state <= M_RST));
            chk("cmp_ce",       32'(CE),         32'(m_state == M_UP));
            chk("cmp_linkup",   32'(LinkUp),     32'(m_state == M_UP));
            chk("cmp_lockfail", 32'(LockFail),   32'(m_lockfail));
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (State !== s && n < budget) begin
            @(negedge Clk);
            n++;
        end
        chk({name, "_reached"}, 32'(State === s), 32'd1);
    endtask

    task automatic count_in(input logic [2:0] s, output int n);
        n = 0;
        while (State === s && n < 500) begin
            n++;
            @(negedge Clk);
        end
    endtask

    logic [3:0] pool [8];
    int n;
    int hold;
    bit left_qual;
    bit saw_qual;

    initial begin
        pool = '{4'b1101, 4'b0101, 4'b0011, 4'b1011, 4'b0001, 4'b1001, 4'b0000, 4'b0111};
        rst = 1'b1; Status = 4'b0000; DcmLocked = 1'b0;
        ForceEn = 1'b0; ForceSpeed = 2'b00; ForceDuplex = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_state",    32'(State),      32'd0);
        chk("rst_arst",     32'(AdapterRst), 32'd1);
        chk("rst_ce",       32'(CE),         32'd0);
        chk("rst_speed",    32'(Speed),      32'd0);
        chk("rst_lockfail", 32'(LockFail),   32'd0);
        rst = 1'b0;

        // Normal 1G bring-up
        Status = 4'b1101; DcmLocked = 1'b1;
        wait_state(3'd1, 10, "g1_qual");
        count_in(3'd1, n);
        chk("g1_qual_len", n, 32'd8);
        chk("g1_rst_arst", 32'(AdapterRst), 32'd1);
        count_in(3'd2, n);
        chk("g1_rst_len", n, 32'd4);
        wait_state(3'd4, 10, "g1_up");
        chk("g1_speed",    32'(Speed),      32'b100);
        chk("g1_duplex",   32'(Duplex),     32'd1);
        chk("g1_phase",    32'(RxClkPhase), 32'd1);
        chk("g1_ce",       32'(CE),         32'd1);
        chk("g1_linkup",   32'(LinkUp),     32'd1);
        chk("g1_lockfail", 32'(LockFail),   32'd0);
        chk("model_g1_up", m_state,         32'd4);

        // Link drop in UP
        Status = 4'b0000;
        @(negedge Clk); chk("drop_up_1", 32'(State), 32'd4);
        @(negedge Clk); chk("drop_up_2", 32'(State), 32'd4);
        @(negedge Clk);
        chk("drop_state",  32'(State),      32'd0);
        chk("drop_ce",     32'(CE),         32'd0);
        chk("drop_linkup", 32'(LinkUp),     32'd0);
        chk("drop_arst",   32'(AdapterRst), 32'd1);
        chk("drop_speed",  32'(Speed),      32'd0);
        chk("model_drop",  m_state,         32'd0);

        // Glitchy status
        left_qual = 1'b0; saw_qual = 1'b0;
        for (int i = 0; i < 50; i++) begin
            Status = (((i / 5) % 2) == 0) ? 4'b0011 : 4'b0001;
            @(negedge Clk);
            if (State > 3'd1) left_qual = 1'b1;
            if (State == 3'd1) saw_qual = 1'b1;
        end
        chk("glitch_stay_qual", 32'(left_qual), 32'd0);
        chk("glitch_saw_qual",  32'(saw_qual),  32'd1);
        Status = 4'b0011;
        wait_state(3'd4, 60, "glitch_up");
        chk("glitch_speed",  32'(Speed),      32'b010);
        chk("glitch_duplex", 32'(Duplex),     32'd0);
        chk("glitch_phase",  32'(RxClkPhase), 32'd0);

        // Lock timeout (also a simultaneous status change and lock drop in UP)
        Status = 4'b0001; DcmLocked = 1'b0;
        wait_state(3'd3, 60, "lt_wait");
        count_in(3'd3, n);
        chk("lt_wait_len",   n,                 32'd20);
        chk("lt_lockfail",   32'(LockFail),     32'd1);
        chk("lt_back_rst",   32'(State),        32'd2);
        chk("model_lt_fail", 32'(m_lockfail),   32'd1);
        DcmLocked = 1'b1;
        wait_state(3'd4, 60, "lt_up");
        chk("lt_speed",      32'(Speed),    32'b001);
        chk("lt_lockfail_2", 32'(LockFail), 32'd1);

        // Reserved speed, then forced configuration
        Status = 4'b0111;
        repeat (20) @(negedge Clk);
        chk("resv_down", 32'(State), 32'd0);
        ForceEn = 1'b1; ForceSpeed = 2'b10; ForceDuplex = 1'b1;
        wait_state(3'd4, 60, "force_up");
        chk("force_speed",  32'(Speed),  32'b100);
        chk("force_duplex", 32'(Duplex), 32'd1);

        // Reset in RST_ADAPT
        ForceEn = 1'b0; Status = 4'b1101;
        wait_state(3'd2, 60, "mid_rst_adapt");
        rst = 1'b1;
        @(negedge Clk);
        rst = 1'b0;
        chk("mid_state",    32'(State),      32'd0);
        chk("mid_speed",    32'(Speed),      32'd0);
        chk("mid_duplex",   32'(Duplex),     32'd0);
        chk("mid_phase",    32'(RxClkPhase), 32'd0);
        chk("mid_arst",     32'(AdapterRst), 32'd1);
        chk("mid_ce",       32'(CE),         32'd0);
        chk("mid_linkup",   32'(LinkUp),     32'd0);
        chk("mid_lockfail", 32'(LockFail),   32'd0);

        // Config change and lock drop on the same cycle in UP
        wait_state(3'd4, 60, "sim_up");
        Status = 4'b0011; DcmLocked = 1'b0;
        repeat (3) @(negedge Clk);
        chk("sim_down", 32'(State), 32'd0);

        // Randomized traffic checked every cycle against the model
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                Status = pool[$urandom_range(0, 7)];
                hold   = $urandom_range(1, 60);
            end
            hold--;
            if ($urandom_range(0, 29) == 0) DcmLocked = ~DcmLocked;
            if ($urandom_range(0, 299) == 0) begin
                ForceEn     = ~ForceEn;
                ForceSpeed  = 2'($urandom_range(0, 3));
                ForceDuplex = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 499) == 0);
            @(negedge Clk);
        end
        rst = 1'b0;
        @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
